power_emu_csr: RTL

Parametrised register front end for a bank of power-emulation cores, replacing the fixed 16-word register file.
- Drives per-channel start/finish controls and captures each channel's wide result into shadow registers, with explicit or automatic snapshots.
- Guarantees tear-free multi-word reads, counts samples per channel, and registers read data with a valid strobe.
- Sits between the host memory-mapped slave port and NUM_CH power-emulation TOP instances.

---
 rtl/power_emu_csr_if.sv | 22 ++
 rtl/power_emu_csr.sv | 129 ++++++++++++
 2 files changed

// File: rtl/power_emu_csr_if.sv
// Host memory-mapped slave bus for the power-emulation register front end.
// The host side drives the request fields; the register block returns registered read data.
interface power_emu_csr_if #(
    parameter int ADDR_W = 5
);
    logic              s_read;
    logic              s_write;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata;
    logic [31:0]       s_rdata;
    logic              s_rvalid;

    modport master (
        output s_read, s_write, s_addr, s_wdata,
        input  s_rdata, s_rvalid
    );

    modport slave (
        input  s_read, s_write, s_addr, s_wdata,
        output s_rdata, s_rvalid
    );
endinterface

// File: rtl/power_emu_csr.sv
// Register front end for NUM_CH power-emulation channels: run/finish control,
// live and shadow result capture, tear-free LO/HI reads, sample counters and scratch.
module power_emu_csr #(
    parameter int NUM_CH = 4,
    parameter int RES_W  = 36,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    power_emu_csr_if.slave          s,
    output logic [NUM_CH-1:0]       ch_start,
    output logic [NUM_CH-1:0]       ch_fin,
    input  logic [NUM_CH*RES_W-1:0] ch_result,
    input  logic [NUM_CH-1:0]       ch_valid
);
    localparam int HOLD_W = RES_W - 32;

    logic [NUM_CH-1:0] r_run;
    logic              r_auto;
    logic [NUM_CH-1:0] r_fin;
    logic [NUM_CH-1:0] r_fresh;
    logic [31:0]       r_snapcnt;
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic [RES_W-1:0]  r_live   [NUM_CH];
    logic [RES_W-1:0]  r_shadow [NUM_CH];
    logic [HOLD_W-1:0] r_hold   [NUM_CH];
    logic [31:0]       r_cnt    [NUM_CH];
    logic [31:0]       r_scr    [NUM_CH];

    logic [31:0]       w_addr;
    logic [31:0]       w_rdata;
    logic              w_wr_ctrl;
    logic              w_wr_fin;
    logic              w_wr_snap;
    logic [NUM_CH-1:0] w_rd_lo;
    logic [NUM_CH-1:0] w_wr_scr;
    logic [NUM_CH-1:0] w_auto_ld;
    logic [NUM_CH-1:0] w_run_rise;
    logic [RES_W-1:0]  w_res [NUM_CH];

    assign ch_start   = r_run;
    assign ch_fin     = r_fin;
    assign s.s_rdata  = r_rdata;
    assign s.s_rvalid = r_rvalid;

    always_comb begin
        w_addr    = 32'(s.s_addr);
        w_wr_ctrl = s.s_write && (w_addr == 32'd0);
        w_wr_fin  = s.s_write && (w_addr == 32'd1);
        w_wr_snap = s.s_write && (w_addr == 32'd3);
        w_rd_lo   = '0;
        w_wr_scr  = '0;
        w_rdata   = '0;
        case (w_addr)
            32'd0: begin
                w_rdata[NUM_CH-1:0] = r_run;
                w_rdata[31]         = r_auto;
            end
            32'd2:   w_rdata = 32'(r_fresh);
            32'd3:   w_rdata = r_snapcnt;
            32'd4:   w_rdata = {8'hE5, 8'd0, 8'(NUM_CH), 8'(RES_W)};
            default: w_rdata = '0;
        endcase
        // Per-channel window at 8+4c; the read mux always sees pre-write state.
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_addr == 8 + 4*c) begin
                w_rdata    = r_shadow[c][31:0];
                w_rd_lo[c] = s.s_read;
            end
            if (w_addr == 9 + 4*c)  w_rdata = 32'(r_hold[c]);
            if (w_addr == 10 + 4*c) w_rdata = r_cnt[c];
            if (w_addr == 11 + 4*c) begin
                w_rdata     = r_scr[c];
                w_wr_scr[c] = s.s_write;
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_res[c]      = ch_result[c*RES_W +: RES_W];
            w_auto_ld[c]  = r_auto && ch_valid[c];
            w_run_rise[c] = w_wr_ctrl && s.s_wdata[c] && !r_run[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run     <= '0;
            r_auto    <= 1'b0;
            r_fin     <= '0;
            r_fresh   <= '0;
            r_snapcnt <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_live[c]   <= '0;
                r_shadow[c] <= '0;
                r_hold[c]   <= '0;
                r_cnt[c]    <= '0;
                r_scr[c]    <= '0;
            end
        end else begin
            r_rvalid <= s.s_read;
            if (s.s_read) r_rdata <= w_rdata;
            if (w_wr_ctrl) begin
                r_run  <= s.s_wdata[NUM_CH-1:0];
                r_auto <= s.s_wdata[31];
            end
            r_fin <= w_wr_fin ? s.s_wdata[NUM_CH-1:0] : '0;
            if (w_wr_snap) r_snapcnt <= r_snapcnt + 32'd1;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_valid[c]) r_live[c] <= w_res[c];
                if (w_auto_ld[c])   r_shadow[c] <= w_res[c];
                else if (w_wr_snap) r_shadow[c] <= r_live[c];
                if (w_rd_lo[c]) r_hold[c] <= r_shadow[c][RES_W-1:32];
                // A shadow load in the same cycle as a LO read keeps the flag set.
                if (w_auto_ld[c] || w_wr_snap) r_fresh[c] <= 1'b1;
                else if (w_rd_lo[c])           r_fresh[c] <= 1'b0;
                if (w_run_rise[c])
                    r_cnt[c] <= '0;
                else if (ch_valid[c] && r_run[c] && (r_cnt[c] != '1))
                    r_cnt[c] <= r_cnt[c] + 32'd1;
                if (w_wr_scr[c]) r_scr[c] <= s.s_wdata;
            end
        end
    end
endmodule
